// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Frame/phase sequencer for the switch core. Counts 0..P-1 with a run-time
// programmable period P, and produces a one-hot phase strobe, a wrap pulse
// on the last phase of each frame, and a completed-frame counter.
// Supports free-run and single-frame modes, pause, and stop-at-frame-end.
// All activity is gated by switch init completion.
//
// Ports:
//   in_clk         clock (rising edge)
//   in_rst         synchronous active-low reset
//   in_init_done   low forces idle (active period and shadow are kept)
//   in_start       one-cycle start request (ignored while busy)
//   in_stop        stop request, honoured at the next frame end
//   in_hold        pause; freezes the counter while high
//   in_single      1 = single-frame, 0 = free-run; sampled on start
//   in_cfg_period  requested period
//   in_cfg_load    captures a clamped in_cfg_period into the shadow register
//   out_cycle_cnt  current phase index
//   out_phase      one-hot of out_cycle_cnt; all zero when idle
//   out_wrap       high in the last phase of a frame while running
//   out_frame_cnt  completed-frame count (wraps)
//   out_busy       high in RUN or HOLD
//   out_period     active period P
module cycle_sequencer #(
  parameter int MAX_PERIOD     = 8,
  parameter int CNT_W          = 3,
  parameter int DEFAULT_PERIOD = 3,
  parameter int FRAME_W        = 8
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_init_done,
  input  logic                  in_start,
  input  logic                  in_stop,
  input  logic                  in_hold,
  input  logic                  in_single,
  input  logic [CNT_W:0]        in_cfg_period,
  input  logic                  in_cfg_load,
  output logic [CNT_W-1:0]      out_cycle_cnt,
  output logic [MAX_PERIOD-1:0] out_phase,
  output logic                  out_wrap,
  output logic [FRAME_W-1:0]    out_frame_cnt,
  output logic                  out_busy,
  output logic [CNT_W:0]        out_period
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W:0] DEF_P = (CNT_W+1)'(DEFAULT_PERIOD);
  localparam logic [CNT_W:0] MAX_P = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [CNT_W:0] ONE_P = (CNT_W+1)'(1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [CNT_W:0]     period;
  logic [CNT_W:0]     shadow;
  logic               stop_pend;
  logic               mode_single;
  logic               last_phase;

  // A zero period would never wrap, so it is promoted to 1; oversized
  // requests saturate at the largest supported period.
  function automatic logic [CNT_W:0] clamp_period(input logic [CNT_W:0] req);
    if (req == '0)
      return ONE_P;
    else if (req > MAX_P)
      return MAX_P;
    else
      return req;
  endfunction

  assign last_phase = ({1'b0, cnt} == (period - ONE_P));

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      frame_cnt   <= '0;
      period      <= DEF_P;
      shadow      <= DEF_P;
      stop_pend   <= 1'b0;
      mode_single <= 1'b0;
    end else if (!in_init_done) begin
      // Init not complete: park idle but keep the programmed periods.
      state       <= S_IDLE;
      cnt         <= '0;
      frame_cnt   <= '0;
      stop_pend   <= 1'b0;
      mode_single <= 1'b0;
    end else begin
      if (in_cfg_load)
        shadow <= clamp_period(in_cfg_period);

      case (state)
        S_IDLE: begin
          // A stop arriving with (or without) a start is ignored here.
          if (in_start) begin
            state       <= S_RUN;
            mode_single <= in_single;
            cnt         <= '0;
            period      <= shadow;
            stop_pend   <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_hold) begin
            // Hold wins over a frame end; the wrap is deferred.
            state <= S_HOLD;
            if (in_stop)
              stop_pend <= 1'b1;
          end else if (last_phase) begin
            cnt       <= '0;
            frame_cnt <= frame_cnt + FRAME_W'(1);
            period    <= shadow;
            // A stop on the frame-end edge itself still ends the run here.
            if (stop_pend || in_stop || mode_single) begin
              state     <= S_IDLE;
              stop_pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (in_stop)
              stop_pend <= 1'b1;
          end
        end
        S_HOLD: begin
          if (in_stop)
            stop_pend <= 1'b1;
          // The release edge only returns to RUN; counting resumes after it.
          if (!in_hold)
            state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_busy      = (state == S_RUN) || (state == S_HOLD);
  assign out_wrap      = (state == S_RUN) && last_phase;
  assign out_cycle_cnt = cnt;
  assign out_frame_cnt = frame_cnt;
  assign out_period    = period;
  assign out_phase     = out_busy ? (MAX_PERIOD'(1) << cnt) : '0;

endmodule
